// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchroniser, mid-bit sampling FSM, one-cycle o_dv / o_frame_err strobes.
// Define UART_RX_MAJORITY_EN to replace each single sample by a 3-sample majority vote (+1 cycle latency).
module uart_rx #(
    parameter int WIDTH         = 8,
    parameter int DIVISOR       = 100,
    parameter int LITTLE_ENDIAN = 0
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_dv,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int H  = DIVISOR / 2;
    localparam int TW = $clog2(DIVISOR);
    localparam int IW = $clog2(WIDTH + 1);

    localparam logic [TW-1:0] T_LAST   = TW'(DIVISOR - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             rx_s_q;
    logic [TW-1:0]    timer_q;
    logic [IW-1:0]    bit_idx_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             sample_bit;
    logic             timer_wrap;

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            rx_s_q  <= sync1_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decisions are taken one cycle after the nominal sample point; the timer
    // restarts at 1 after the start bit so later targets keep their spacing.
    localparam logic [TW-1:0] START_DECIDE = TW'(H);
    localparam logic [TW-1:0] BIT_DECIDE   = '0;
    localparam logic [TW-1:0] DATA_T0      = TW'(1);

    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s_q};
        end
    end

    assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    localparam logic [TW-1:0] START_DECIDE = TW'(H - 1);
    localparam logic [TW-1:0] BIT_DECIDE   = T_LAST;
    localparam logic [TW-1:0] DATA_T0      = '0;

    assign sample_bit = rx_s_q;
`endif

    assign timer_wrap = (timer_q == T_LAST);

    generate
        if (WIDTH == 1) begin : g_shift_one
            assign shift_d = sample_bit;
        end else if (LITTLE_ENDIAN != 0) begin : g_shift_lsb_first
            assign shift_d = {sample_bit, shift_q[WIDTH-1:1]};
        end else begin : g_shift_msb_first
            assign shift_d = {shift_q[WIDTH-2:0], sample_bit};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            o_data      <= '0;
            o_dv        <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_dv        <= 1'b0;
            o_frame_err <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        timer_q <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (timer_q == START_DECIDE) begin
                        if (sample_bit) begin
                            state_q <= S_IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            state_q   <= S_DATA;
                            timer_q   <= DATA_T0;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DATA: begin
                    timer_q <= timer_wrap ? '0 : timer_q + TW'(1);
                    if (timer_q == BIT_DECIDE) begin
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + IW'(1);
                        if (bit_idx_q == IDX_LAST) begin
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    timer_q <= timer_wrap ? '0 : timer_q + TW'(1);
                    if (timer_q == BIT_DECIDE) begin
                        if (sample_bit) begin
                            o_data  <= shift_q;
                            o_dv    <= 1'b1;
                            state_q <= S_IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            o_frame_err <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // A line held low after a bad stop bit must not start new frames.
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an MSB-first and an LSB-first receiver share one
// serial line driven cycle by cycle by a behavioural transmitter task.
module tb_uart_rx;

    localparam int W = 8;
    localparam int D = 100;
    localparam int H = D / 2;
    localparam int NO_EVENT = 1000000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_be, data_le;
    logic       dv_be, dv_le, err_be, err_le, busy_be, busy_le;

    always #5 clk = ~clk;

    uart_rx #(.WIDTH(W), .DIVISOR(D), .LITTLE_ENDIAN(0)) dut (
        .clk(clk), .i_reset_n(rst_n), .i_rx(rx),
        .o_data(data_be), .o_dv(dv_be), .o_frame_err(err_be), .o_busy(busy_be)
    );

    uart_rx #(.WIDTH(W), .DIVISOR(D), .LITTLE_ENDIAN(1)) dut_le (
        .clk(clk), .i_reset_n(rst_n), .i_rx(rx),
        .o_data(data_le), .o_dv(dv_le), .o_frame_err(err_le), .o_busy(busy_le)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         dv_cnt   = 0;
    int         err_cnt  = 0;
    int         both_cnt = 0;
    int         dv_cyc  [0:31];
    logic [7:0] dv_word [0:31];

    always @(negedge clk) begin
        if (dv_be) begin
            dv_word[dv_cnt % 32] <= data_be;
            dv_cyc[dv_cnt % 32]  <= cyc;
            dv_cnt               <= dv_cnt + 1;
            $display("rx word 0x%02h at cycle %0d", data_be, cyc);
        end
        if (err_be) begin
            err_cnt <= err_cnt + 1;
            $display("rx frame error at cycle %0d", cyc);
        end
        if (dv_be && err_be) both_cnt <= both_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One 10-bit frame, MSB first; glitch_j inverts one line cycle, abort_j
    // pulses reset for two cycles and releases the line from then on.
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input int glitch_j, input int abort_j, output int t0);
        t0 = 0;
        for (int j = 0; j < 10 * D; j++) begin
            logic lvl;
            @(negedge clk);
            if (j == 0) t0 = cyc + 1;
            if (j < D)          lvl = 1'b0;
            else if (j < 9 * D) lvl = data[7 - (j / D - 1)];
            else                lvl = stop_val;
            if (j == glitch_j) lvl = ~lvl;
            if (j >= abort_j)  lvl = 1'b1;
            rst_n = !(j == abort_j || j == abort_j + 1);
            rx    = lvl;
        end
    endtask

    initial begin
        int   t0, t1, t2, base_dv, base_err, low_busy;
        logic saw_busy;
        logic [7:0] glitch_exp;

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_data", {24'd0, data_be}, 32'h0);
        check("reset_dv", {31'd0, dv_be}, 32'h0);
        check("reset_err", {31'd0, err_be}, 32'h0);
        check("reset_busy", {31'd0, busy_be}, 32'h0);
        check("reset_le_data", {24'd0, data_le}, 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // False start: 20 low cycles, then idle.
        base_dv  = dv_cnt;
        base_err = err_cnt;
        saw_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 19) rx = 1'b1;
            if (busy_be) saw_busy = 1'b1;
        end
        check("false_start_busy_seen", {31'd0, saw_busy}, 32'h1);
        check("false_start_busy_end", {31'd0, busy_be}, 32'h0);
        check("false_start_dv", dv_cnt - base_dv, 0);
        check("false_start_err", err_cnt - base_err, 0);
        repeat (20) @(negedge clk);

        // First data bit 1, rest 0: MSB-first sees 0x80, LSB-first sees 0x01.
        base_dv = dv_cnt;
        send_frame(8'h80, 1'b1, -1, NO_EVENT, t0);
        repeat (2) @(negedge clk);
        check("endian_dv", dv_cnt - base_dv, 1);
        check("endian_msb_first", {24'd0, data_be}, 32'h80);
        check("endian_lsb_first", {24'd0, data_le}, 32'h01);
        repeat (20) @(negedge clk);

        // Single frame 0xA5 with latency check.
        base_dv  = dv_cnt;
        base_err = err_cnt;
        send_frame(8'hA5, 1'b1, -1, NO_EVENT, t0);
        repeat (2) @(negedge clk);
        check("a5_dv_count", dv_cnt - base_dv, 1);
        check("a5_word", {24'd0, dv_word[base_dv % 32]}, 32'hA5);
        check("a5_err", err_cnt - base_err, 0);
        check_rng("a5_latency", dv_cyc[base_dv % 32] - t0, 3 + H + 9 * D - 1, 3 + H + 9 * D + 1);
        repeat (20) @(negedge clk);

        // Stop bit low, then line held low as a break.
        base_dv  = dv_cnt;
        base_err = err_cnt;
        send_frame(8'h5A, 1'b0, -1, NO_EVENT, t0);
        low_busy = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rx = 1'b0;
            if (!busy_be) low_busy++;
        end
        check("break_err_count", err_cnt - base_err, 1);
        check("break_dv_count", dv_cnt - base_dv, 0);
        check("break_data_held", {24'd0, data_be}, 32'hA5);
        check("break_busy_low_cycles", low_busy, 0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("break_release_busy", {31'd0, busy_be}, 32'h0);

        base_dv = dv_cnt;
        send_frame(8'h11, 1'b1, -1, NO_EVENT, t0);
        repeat (2) @(negedge clk);
        check("after_break_dv", dv_cnt - base_dv, 1);
        check("after_break_data", {24'd0, data_be}, 32'h11);
        repeat (20) @(negedge clk);

        // Back-to-back frames, no idle gap.
        base_dv = dv_cnt;
        send_frame(8'h00, 1'b1, -1, NO_EVENT, t0);
        send_frame(8'hFF, 1'b1, -1, NO_EVENT, t1);
        send_frame(8'h3C, 1'b1, -1, NO_EVENT, t2);
        repeat (2) @(negedge clk);
        check("b2b_count", dv_cnt - base_dv, 3);
        check("b2b_word0", {24'd0, dv_word[base_dv % 32]}, 32'h00);
        check("b2b_word1", {24'd0, dv_word[(base_dv + 1) % 32]}, 32'hFF);
        check("b2b_word2", {24'd0, dv_word[(base_dv + 2) % 32]}, 32'h3C);
        check_rng("b2b_gap01", dv_cyc[(base_dv + 1) % 32] - dv_cyc[base_dv % 32], 10 * D - 1, 10 * D + 1);
        check_rng("b2b_gap12", dv_cyc[(base_dv + 2) % 32] - dv_cyc[(base_dv + 1) % 32], 10 * D - 1, 10 * D + 1);
        repeat (20) @(negedge clk);

        // Reset in the middle of data bit 3 of 0xC3.
        base_dv  = dv_cnt;
        base_err = err_cnt;
        send_frame(8'hC3, 1'b1, -1, 4 * D + H, t0);
        repeat (2) @(negedge clk);
        check("midreset_data", {24'd0, data_be}, 32'h0);
        check("midreset_busy", {31'd0, busy_be}, 32'h0);
        check("midreset_dv", dv_cnt - base_dv, 0);
        check("midreset_err", err_cnt - base_err, 0);
        base_dv = dv_cnt;
        send_frame(8'h7E, 1'b1, -1, NO_EVENT, t0);
        repeat (2) @(negedge clk);
        check("post_reset_dv", dv_cnt - base_dv, 1);
        check("post_reset_data", {24'd0, data_be}, 32'h7E);
        repeat (20) @(negedge clk);

        // One-cycle glitch on the sample point of data bit 2 of 0x0F.
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h0F;
`else
        glitch_exp = 8'h2F;
`endif
        base_dv = dv_cnt;
        send_frame(8'h0F, 1'b1, H + 3 * D, NO_EVENT, t0);
        repeat (2) @(negedge clk);
        check("glitch_dv", dv_cnt - base_dv, 1);
        check("glitch_data", {24'd0, data_be}, {24'd0, glitch_exp});

        check("dv_err_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
